// File: rtl/mem_bus_ctrl.sv
// Serialises the core's fetch, load and store channels onto one single-port word bus.
// Fixed priority store > load > inst; registered responses; bus timeout sets a sticky error.
module mem_bus_ctrl #(
  parameter int W           = 32,
  parameter int BUS_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_req,
  input  logic [W-1:0] inst_addr,
  output logic [W-1:0] inst_data,
  output logic         inst_done,
  input  logic         load_req,
  input  logic [W-1:0] load_addr,
  output logic [W-1:0] load_data,
  output logic         load_done,
  input  logic         store_req,
  input  logic [W-1:0] store_addr,
  input  logic [W-1:0] store_data,
  output logic         store_done,
  output logic         busy,
  output logic         bus_cyc,
  output logic         bus_we,
  output logic [W-1:0] bus_addr,
  output logic [W-1:0] bus_wdata,
  input  logic [W-1:0] bus_rdata,
  input  logic         bus_ack,
  output logic         bus_err
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  typedef enum logic [1:0] {CH_INST, CH_LOAD, CH_STORE} chan_t;

  localparam logic [7:0]   CNT_LAST   = 8'(BUS_TIMEOUT - 1);
  localparam logic [W-1:0] ALIGN_MASK = ~W'(3);

  state_t       state_q, state_d;
  chan_t        chan_q, chan_d;
  logic         we_q, we_d;
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [W-1:0] inst_data_q, inst_data_d;
  logic [W-1:0] load_data_q, load_data_d;
  logic         err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      chan_q      <= CH_INST;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      inst_data_q <= '0;
      load_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      inst_data_q <= inst_data_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    inst_data_d = inst_data_q;
    load_data_d = load_data_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (store_req) begin
          chan_d  = CH_STORE;
          we_d    = 1'b1;
          addr_d  = store_addr & ALIGN_MASK;
          wdata_d = store_data;
          state_d = BUS;
        end else if (load_req) begin
          chan_d  = CH_LOAD;
          we_d    = 1'b0;
          addr_d  = load_addr & ALIGN_MASK;
          wdata_d = '0;
          state_d = BUS;
        end else if (inst_req) begin
          chan_d  = CH_INST;
          we_d    = 1'b0;
          addr_d  = inst_addr & ALIGN_MASK;
          wdata_d = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (bus_ack) begin
          if (chan_q == CH_LOAD) load_data_d = bus_rdata;
          if (chan_q == CH_INST) inst_data_d = bus_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Aborted reads return zero so the core never sees stale data.
          if (chan_q == CH_LOAD) load_data_d = '0;
          if (chan_q == CH_INST) inst_data_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign bus_cyc    = (state_q == BUS);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_err    = err_q;
  assign inst_data  = inst_data_q;
  assign load_data  = load_data_q;
  assign inst_done  = (state_q == DONE) && (chan_q == CH_INST);
  assign load_done  = (state_q == DONE) && (chan_q == CH_LOAD);
  assign store_done = (state_q == DONE) && (chan_q == CH_STORE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: hand-computed expectations checked with immediate assertions.
module tb_mem_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, load_req, store_req;
  logic [31:0] inst_addr, load_addr, store_addr, store_data;
  logic [31:0] inst_data, load_data;
  logic        inst_done, load_done, store_done;
  logic        busy, bus_cyc, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int errors = 0;
  int checks = 0;
  int n;

  mem_bus_ctrl #(.W(32), .BUS_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_data(inst_data), .inst_done(inst_done),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
    .store_done(store_done), .busy(busy), .bus_cyc(bus_cyc), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; load_req = 0; store_req = 0;
    inst_addr = 0; load_addr = 0; store_addr = 0; store_data = 0;
    bus_ack = 0; bus_rdata = 0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cyc", {31'd0, bus_cyc}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    chk("rst_idata", inst_data, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_dones", {29'd0, inst_done, load_done, store_done}, 32'd0);

    // zero-wait fetch
    inst_req = 1; inst_addr = 32'h0040_0000; bus_ack = 1; bus_rdata = 32'h2402_0005;
    step();
    chk("zw_cyc", {31'd0, bus_cyc}, 32'd1);
    chk("zw_we", {31'd0, bus_we}, 32'd0);
    chk("zw_addr", bus_addr, 32'h0040_0000);
    chk("zw_wdata", bus_wdata, 32'd0);
    step();
    chk("zw_done", {29'd0, inst_done, load_done, store_done}, 32'b100);
    chk("zw_cyc_off", {31'd0, bus_cyc}, 32'd0);
    chk("zw_idata", inst_data, 32'h2402_0005);
    chk("zw_ldata", load_data, 32'd0);
    inst_req = 0; bus_ack = 0;
    step();
    chk("zw_idle", {30'd0, busy, inst_done}, 32'd0);

    // arbitration: store, then load, then inst
    store_req = 1; store_addr = 32'h1001_0000; store_data = 32'hCAFE_BABE;
    load_req = 1; load_addr = 32'h1001_0004;
    inst_req = 1; inst_addr = 32'h0040_0004;
    bus_ack = 1; bus_rdata = 32'h1111_1111;
    step();
    chk("arb1_we", {31'd0, bus_we}, 32'd1);
    chk("arb1_addr", bus_addr, 32'h1001_0000);
    chk("arb1_wdata", bus_wdata, 32'hCAFE_BABE);
    step();
    chk("arb1_done", {29'd0, inst_done, load_done, store_done}, 32'b001);
    chk("arb1_idata", inst_data, 32'h2402_0005);
    chk("arb1_ldata", load_data, 32'd0);
    store_req = 0;
    step();
    chk("arb_gap1", {29'd0, inst_done, load_done, store_done}, 32'd0);
    bus_rdata = 32'h5555_AAAA;
    step();
    chk("arb2_we", {31'd0, bus_we}, 32'd0);
    chk("arb2_addr", bus_addr, 32'h1001_0004);
    chk("arb2_wdata", bus_wdata, 32'd0);
    step();
    chk("arb2_done", {29'd0, inst_done, load_done, store_done}, 32'b010);
    chk("arb2_ldata", load_data, 32'h5555_AAAA);
    load_req = 0;
    step();
    bus_rdata = 32'h8C22_0000;
    step();
    chk("arb3_we", {31'd0, bus_we}, 32'd0);
    chk("arb3_addr", bus_addr, 32'h0040_0004);
    step();
    chk("arb3_done", {29'd0, inst_done, load_done, store_done}, 32'b100);
    chk("arb3_idata", inst_data, 32'h8C22_0000);
    chk("arb3_ldata", load_data, 32'h5555_AAAA);
    inst_req = 0; bus_ack = 0;
    step();

    // three wait states before ack
    load_req = 1; load_addr = 32'h2000_0010; bus_rdata = 32'hDEAD_BEEF;
    step();
    chk("ws_c1", {bus_cyc, bus_addr[30:0]}, {1'b1, 31'h2000_0010});
    load_addr = 32'h7777_7770;
    step();
    chk("ws_c2", {bus_cyc, bus_addr[30:0]}, {1'b1, 31'h2000_0010});
    step();
    chk("ws_c3", {bus_cyc, bus_addr[30:0]}, {1'b1, 31'h2000_0010});
    step();
    chk("ws_c4", {bus_cyc, bus_addr[30:0]}, {1'b1, 31'h2000_0010});
    chk("ws_c4_nodone", {31'd0, load_done}, 32'd0);
    bus_ack = 1;
    step();
    chk("ws_done", {29'd0, inst_done, load_done, store_done}, 32'b010);
    chk("ws_ldata", load_data, 32'hDEAD_BEEF);
    chk("ws_err", {31'd0, bus_err}, 32'd0);
    load_req = 0; bus_ack = 0;
    step();

    // timeout: no ack at all
    load_req = 1; load_addr = 32'h3000_0000;
    step();
    n = 0;
    while (bus_cyc && n < 40) begin
      n++;
      step();
    end
    chk("to_cycles", n, 32'd15);
    chk("to_done", {29'd0, inst_done, load_done, store_done}, 32'b010);
    chk("to_ldata", load_data, 32'd0);
    chk("to_err", {31'd0, bus_err}, 32'd1);
    load_req = 0;
    step();

    // unaligned fetch held through the IDLE cycle after DONE
    inst_req = 1; inst_addr = 32'h0000_1003; bus_ack = 1; bus_rdata = 32'h0000_ABCD;
    step();
    chk("al_addr", bus_addr, 32'h0000_1000);
    step();
    chk("al_done1", {31'd0, inst_done}, 32'd1);
    chk("al_idata", inst_data, 32'h0000_ABCD);
    step();
    chk("al_idle", {31'd0, busy}, 32'd0);
    step();
    chk("al_again", {bus_cyc, bus_addr[30:0]}, {1'b1, 31'h0000_1000});
    step();
    chk("al_done2", {31'd0, inst_done}, 32'd1);
    inst_req = 0; bus_ack = 0;
    step();
    chk("err_sticky", {31'd0, bus_err}, 32'd1);

    // reset in the middle of a bus cycle
    load_req = 1; load_addr = 32'h4000_0000;
    step();
    chk("rm_cyc", {31'd0, bus_cyc}, 32'd1);
    rst = 1;
    step();
    rst = 0; load_req = 0; bus_ack = 1; bus_rdata = 32'h1234_5678;
    chk("rm_outs", {27'd0, busy, bus_cyc, inst_done, load_done, store_done}, 32'd0);
    chk("rm_err", {31'd0, bus_err}, 32'd0);
    chk("rm_idata", inst_data, 32'd0);
    chk("rm_addr", bus_addr, 32'd0);
    step();
    chk("rm_late", {29'd0, busy, bus_cyc, load_done}, 32'd0);
    chk("rm_ldata", load_data, 32'd0);
    bus_ack = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
